// File: rtl/expipe_pkg.sv
// Execution-pipeline shared types: reorder buffer sizing and entry layout.
package expipe_pkg;

    import len5_pkg::*;

    localparam int unsigned ROB_DEPTH      = 8;
    localparam int unsigned ROB_IDX_LEN    = $clog2(ROB_DEPTH);
    localparam int unsigned ROB_EXCEPT_LEN = 5;

    typedef struct packed {
        logic                      busy;
        logic                      res_ready;
        logic [ILEN-1:0]           instr;
        logic [XLEN-1:0]           pc;
        logic [REG_IDX_LEN-1:0]    rd_idx;
        logic [XLEN-1:0]           value;
        logic                      except_raised;
        logic [ROB_EXCEPT_LEN-1:0] except_code;
    } rob_entry_t;

endpackage

// File: rtl/len5_pkg.sv
// Core-wide architectural widths shared across the pipeline.
package len5_pkg;

    localparam int unsigned ILEN        = 32;
    localparam int unsigned XLEN        = 64;
    localparam int unsigned REG_IDX_LEN = 5;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order CDB completion,
// in-order retirement of the head entry through a valid/ready handshake.
module reorder_buffer
    import len5_pkg::*;
    import expipe_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,

    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [ILEN-1:0]           issue_instr_i,
    input  logic [XLEN-1:0]           issue_pc_i,
    input  logic [REG_IDX_LEN-1:0]    issue_rd_idx_i,
    input  logic                      issue_res_ready_i,
    output logic [ROB_IDX_LEN-1:0]    issue_idx_o,

    input  logic                      cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0]    cdb_idx_i,
    input  logic [XLEN-1:0]           cdb_value_i,
    input  logic                      cdb_except_raised_i,
    input  logic [ROB_EXCEPT_LEN-1:0] cdb_except_code_i,

    output logic                      rob_valid_o,
    input  logic                      rob_ready_i,
    output logic [ILEN-1:0]           rob_instr_o,
    output logic [XLEN-1:0]           rob_pc_o,
    output logic [REG_IDX_LEN-1:0]    rob_rd_idx_o,
    output logic [XLEN-1:0]           rob_value_o,
    output logic                      rob_except_raised_o,
    output logic [ROB_EXCEPT_LEN-1:0] rob_except_code_o,
    output logic [ROB_IDX_LEN-1:0]    rob_head_idx_o
);

    localparam int unsigned              CNT_W    = ROB_IDX_LEN + 1;
    localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic [ROB_IDX_LEN-1:0]   IDX_ONE  = ROB_IDX_LEN'(1);

    rob_entry_t             data_q [DEPTH];
    rob_entry_t             data_d [DEPTH];
    logic [ROB_IDX_LEN-1:0] head_q, head_d;
    logic [ROB_IDX_LEN-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    rob_entry_t head_entry;
    logic       do_issue;
    logic       do_pop;

    assign head_entry    = data_q[head_q];
    assign issue_ready_o = (count_q != FULL_CNT);
    assign issue_idx_o   = tail_q;
    assign rob_valid_o   = head_entry.busy & head_entry.res_ready;
    assign do_issue      = issue_valid_i & issue_ready_o;
    assign do_pop        = rob_valid_o & rob_ready_i;

    // Head fields are masked when the slot is free so stale payload never leaks out.
    assign rob_instr_o         = head_entry.busy ? head_entry.instr         : '0;
    assign rob_pc_o            = head_entry.busy ? head_entry.pc            : '0;
    assign rob_rd_idx_o        = head_entry.busy ? head_entry.rd_idx        : '0;
    assign rob_value_o         = head_entry.busy ? head_entry.value         : '0;
    assign rob_except_raised_o = head_entry.busy ? head_entry.except_raised : 1'b0;
    assign rob_except_code_o   = head_entry.busy ? head_entry.except_code   : '0;
    assign rob_head_idx_o      = head_q;

    always_comb begin
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_d[i].busy      = 1'b0;
                data_d[i].res_ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_valid_i && data_q[cdb_idx_i].busy) begin
                data_d[cdb_idx_i].value         = cdb_value_i;
                data_d[cdb_idx_i].except_raised = cdb_except_raised_i;
                data_d[cdb_idx_i].except_code   = cdb_except_code_i;
                data_d[cdb_idx_i].res_ready     = 1'b1;
            end
            if (do_pop) begin
                data_d[head_q].busy      = 1'b0;
                data_d[head_q].res_ready = 1'b0;
                head_d                   = head_q + IDX_ONE;
            end
            if (do_issue) begin
                data_d[tail_q] = '{busy:          1'b1,
                                   res_ready:     issue_res_ready_i,
                                   instr:         issue_instr_i,
                                   pc:            issue_pc_i,
                                   rd_idx:        issue_rd_idx_i,
                                   value:         '0,
                                   except_raised: 1'b0,
                                   except_code:   '0};
                tail_d = tail_q + IDX_ONE;
            end
            case ({do_issue, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
